// File: rtl/cis_pkg.sv
// cis_pkg: shared state/colour encodings and default line timing for the CIS line sequencer
package cis_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} cis_state_t;
  localparam logic [1:0] COL_R = 2'd0;
  localparam logic [1:0] COL_G = 2'd1;
  localparam logic [1:0] COL_B = 2'd2;
  localparam int LINE_300_DEF = 2700;
  localparam int LINE_600_DEF = 5300;
  localparam int LED_OFF_DEF = 40;
  localparam int LED_ON_DEF = 70;
  // R -> G -> B -> R when sequencing, otherwise parked on R (all LEDs driven together)
  function automatic logic [1:0] next_color(input logic [1:0] c, input bit seq);
    return !seq ? COL_R : (c == COL_B) ? COL_R : c + 2'd1;
  endfunction
endpackage

// File: rtl/cis_clk_div.sv
// cis_clk_div: USB_CLK divider producing the period tick, CIS/ADC clock phases and the FIFO write strobe
module cis_clk_div #(
  parameter int CLK_DIV = 6,
  parameter int ADC_DELAY = 3,
  parameter int WR_POS = 2
) (
  input  logic USB_CLK,
  input  logic RST_L,
  input  logic run_nxt,
  output logic tick,
  output logic CIS_CLK,
  output logic ADC_CLK,
  output logic USB_WR_L
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] ADC_D = DW'(ADC_DELAY);
  localparam logic [DW-1:0] ADC_W = DW'(CLK_DIV - ADC_DELAY);
  localparam logic [DW-1:0] WR_P = DW'(WR_POS);
  logic [DW-1:0] div_cnt, div_nxt, adc_ph;
  assign tick = div_cnt == LAST;
  assign div_nxt = tick ? '0 : div_cnt + DW'(1);
  assign adc_ph = (div_nxt >= ADC_D) ? div_nxt - ADC_D : div_nxt + ADC_W;
  // outputs are registered from the next divider phase so they line up with div_cnt itself
  always_ff @(posedge USB_CLK or negedge RST_L)
    if (!RST_L) begin
      div_cnt <= '0;
      CIS_CLK <= 1'b0;
      ADC_CLK <= 1'b0;
      USB_WR_L <= 1'b1;
    end else begin
      div_cnt <= div_nxt;
      CIS_CLK <= run_nxt && div_nxt < HALF;
      ADC_CLK <= adc_ph < HALF;
      USB_WR_L <= !(run_nxt && div_nxt == WR_P);
    end
endmodule

// File: rtl/cis_line_sequencer.sv
// cis_line_sequencer: CIS line timing with run/stop, per-line DPI latch, RGB LED sequencing and line counting
module cis_line_sequencer
  import cis_pkg::*;
#(
  parameter int CLK_DIV = 6,
  parameter int ADC_DELAY = 3,
  parameter int WR_POS = 2,
  parameter int LINE_300 = LINE_300_DEF,
  parameter int LINE_600 = LINE_600_DEF,
  parameter int LED_OFF = LED_OFF_DEF,
  parameter int LED_ON = LED_ON_DEF,
  parameter int SYNC_POS = 1000,
  parameter int COLOR_SEQ = 1,
  parameter int PIX_W = 13,
  parameter int LINE_W = 16
) (
  input  logic USB_CLK,
  input  logic RST_L,
  input  logic EN,
  input  logic DPI_600,
  output logic CIS_MODE,
  output logic CIS_CLK,
  output logic CIS_SP,
  output logic CIS_LED_RED,
  output logic CIS_LED_GREEN,
  output logic CIS_LED_BLUE,
  output logic ADC_CLK,
  output logic USB_WR_L,
  output logic SCOPE_SYNC,
  output logic [LINE_W-1:0] LINE_CNT,
  output logic [1:0] COLOR,
  output logic BUSY
);
  localparam logic [PIX_W-1:0] ONE = PIX_W'(1);
  localparam logic [PIX_W-1:0] L300 = PIX_W'(LINE_300);
  localparam logic [PIX_W-1:0] L600 = PIX_W'(LINE_600);
  localparam logic [PIX_W-1:0] OFF = PIX_W'(LED_OFF);
  localparam logic [PIX_W-1:0] ON = PIX_W'(LED_ON);
  localparam logic [PIX_W-1:0] SYNC = PIX_W'(SYNC_POS);
  cis_state_t state, state_nxt;
  logic [PIX_W-1:0] pix_cnt, pix_nxt, line_len;
  logic [LINE_W-1:0] line_nxt;
  logic [1:0] color_nxt;
  logic mode_nxt, tick, active, eol, run_nxt, led_win;
  assign line_len = CIS_MODE ? L600 : L300;
  assign active = state == RUN || state == DRAIN;
  assign eol = active && tick && pix_cnt == line_len;
  assign run_nxt = state_nxt == RUN || state_nxt == DRAIN;
  assign led_win = run_nxt && !(pix_nxt >= OFF && pix_nxt < ON);
  cis_clk_div #(.CLK_DIV(CLK_DIV), .ADC_DELAY(ADC_DELAY), .WR_POS(WR_POS)) u_div (
    .USB_CLK(USB_CLK),
    .RST_L(RST_L),
    .run_nxt(run_nxt),
    .tick(tick),
    .CIS_CLK(CIS_CLK),
    .ADC_CLK(ADC_CLK),
    .USB_WR_L(USB_WR_L)
  );
  // scan state: ARM waits for a period boundary so RUN starts on a fresh CIS_CLK high phase
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (EN) state_nxt = ARM;
      ARM: if (!EN) state_nxt = IDLE; else if (tick) state_nxt = RUN;
      RUN: if (!EN) state_nxt = DRAIN;
      DRAIN: if (EN) state_nxt = RUN; else if (eol) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // pixel/line/colour bookkeeping; a line start latches the DPI selection for the whole line
  always_comb begin
    pix_nxt = pix_cnt;
    line_nxt = LINE_CNT;
    color_nxt = COLOR;
    mode_nxt = CIS_MODE;
    if (state == IDLE && EN) begin
      pix_nxt = ONE;
      line_nxt = '0;
      color_nxt = COL_R;
    end
    if (state == ARM && state_nxt == RUN) mode_nxt = DPI_600;
    if (active && tick) pix_nxt = eol ? ONE : pix_cnt + ONE;
    if (eol) begin
      line_nxt = LINE_CNT + LINE_W'(1);
      color_nxt = next_color(COLOR, COLOR_SEQ != 0);
      mode_nxt = (state_nxt == IDLE) ? CIS_MODE : DPI_600;
    end
  end
  // state, counters and decoded outputs, all decoded from next values so they switch together
  always_ff @(posedge USB_CLK or negedge RST_L)
    if (!RST_L) begin
      state <= IDLE;
      pix_cnt <= ONE;
      LINE_CNT <= '0;
      COLOR <= COL_R;
      CIS_MODE <= 1'b0;
      CIS_SP <= 1'b0;
      CIS_LED_RED <= 1'b0;
      CIS_LED_GREEN <= 1'b0;
      CIS_LED_BLUE <= 1'b0;
      SCOPE_SYNC <= 1'b0;
      BUSY <= 1'b0;
    end else begin
      state <= state_nxt;
      pix_cnt <= pix_nxt;
      LINE_CNT <= line_nxt;
      COLOR <= color_nxt;
      CIS_MODE <= mode_nxt;
      CIS_SP <= run_nxt && pix_nxt == ONE;
      CIS_LED_RED <= led_win && (COLOR_SEQ == 0 || color_nxt == COL_R);
      CIS_LED_GREEN <= led_win && (COLOR_SEQ == 0 || color_nxt == COL_G);
      CIS_LED_BLUE <= led_win && (COLOR_SEQ == 0 || color_nxt == COL_B);
      SCOPE_SYNC <= run_nxt && pix_nxt == SYNC;
      BUSY <= state_nxt != IDLE;
    end
endmodule

// File: tb/tb_cis_line_sequencer.sv
// tb_cis_line_sequencer: scoreboard bench for line timing, colour sequencing, DPI latch, drain and async reset
module tb_cis_line_sequencer;
  localparam int DIV = 6;
  localparam int L300 = 150;
  localparam int L600 = 250;
  logic USB_CLK = 1'b0;
  logic RST_L, EN, DPI_600;
  logic CIS_MODE, CIS_CLK, CIS_SP, CIS_LED_RED, CIS_LED_GREEN, CIS_LED_BLUE;
  logic ADC_CLK, USB_WR_L, SCOPE_SYNC, BUSY;
  logic [15:0] LINE_CNT;
  logic [1:0] COLOR;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    bit stop;
    int cnt;
    int color;
    bit mode;
    bit [2:0] leds;
    int len;
  } ev_t;
  ev_t q[$];
  ev_t e;
  int cyc, pix, dark, first_dark, sync_pix, sync_n, sync_hi;
  bit p_sp, p_busy, p_cis, p_sync;

  cis_line_sequencer #(
    .CLK_DIV(6), .ADC_DELAY(3), .WR_POS(2), .LINE_300(L300), .LINE_600(L600),
    .LED_OFF(40), .LED_ON(70), .SYNC_POS(100), .COLOR_SEQ(1), .PIX_W(13), .LINE_W(16)
  ) dut (
    .USB_CLK(USB_CLK), .RST_L(RST_L), .EN(EN), .DPI_600(DPI_600),
    .CIS_MODE(CIS_MODE), .CIS_CLK(CIS_CLK), .CIS_SP(CIS_SP),
    .CIS_LED_RED(CIS_LED_RED), .CIS_LED_GREEN(CIS_LED_GREEN), .CIS_LED_BLUE(CIS_LED_BLUE),
    .ADC_CLK(ADC_CLK), .USB_WR_L(USB_WR_L), .SCOPE_SYNC(SCOPE_SYNC),
    .LINE_CNT(LINE_CNT), .COLOR(COLOR), .BUSY(BUSY)
  );

  always #5 USB_CLK = ~USB_CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_sp(input int lim, output int n);
    bit p;
    n = 0;
    do begin
      p = CIS_SP;
      @(negedge USB_CLK);
      n++;
    end while (!(CIS_SP && !p) && n < lim);
    n_chk++;
    if (!(CIS_SP && !p)) begin
      n_fail++;
      $display("FAIL sp_timeout: got no CIS_SP rise within %0d cycles, expected one", lim);
    end
  endtask

  task automatic wait_idle(input int lim, output int n);
    bit p;
    n = 0;
    do begin
      p = BUSY;
      @(negedge USB_CLK);
      n++;
    end while (!(!BUSY && p) && n < lim);
    n_chk++;
    if (!(!BUSY && p)) begin
      n_fail++;
      $display("FAIL idle_timeout: got no BUSY fall within %0d cycles, expected one", lim);
    end
  endtask

  // monitor: each line start (SP rise) or scan end (BUSY fall) pops one expected record
  initial begin
    cyc = 0; pix = 0; dark = 0; first_dark = 0; sync_pix = 0; sync_n = 0; sync_hi = 0;
    forever begin
      @(negedge USB_CLK);
      cyc++;
      if ((CIS_SP && !p_sp) || (!BUSY && p_busy)) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got line event at %0t, expected none", $time);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(!BUSY), 32'(e.stop));
          chk("line_cnt", 32'(LINE_CNT), e.cnt);
          chk("color", 32'(COLOR), e.color);
          chk("cis_mode", 32'(CIS_MODE), 32'(e.mode));
          chk("leds_rgb", 32'({CIS_LED_RED, CIS_LED_GREEN, CIS_LED_BLUE}), 32'(e.leds));
          if (e.len != 0) begin
            chk("line_cycles", cyc, e.len * DIV);
            chk("line_pixels", pix, e.len);
            chk("led_dark_pixels", dark, 30);
            chk("led_off_pix", first_dark, 40);
            chk("sync_pix", sync_pix, 100);
            chk("sync_pulses", sync_n, 1);
            chk("sync_width", sync_hi, DIV);
          end
        end
        cyc = 0; pix = 0; dark = 0; first_dark = 0; sync_pix = 0; sync_n = 0; sync_hi = 0;
      end
      if (CIS_CLK && !p_cis) begin
        pix++;
        if (!(CIS_LED_RED || CIS_LED_GREEN || CIS_LED_BLUE)) begin
          dark++;
          if (first_dark == 0) first_dark = pix;
        end
      end
      if (SCOPE_SYNC) begin
        sync_hi++;
        if (!p_sync) begin
          sync_n++;
          sync_pix = pix;
        end
      end
      p_sp = CIS_SP; p_busy = BUSY; p_cis = CIS_CLK; p_sync = SCOPE_SYNC;
    end
  end

  // stimulus: directed scan sequence, pushing the expected line records ahead of each event
  initial begin
    int n, n2, hi, rises;
    logic [5:0] v_cis, v_adc, v_wr, v_sp;
    bit p;
    RST_L = 1'b0; EN = 1'b0; DPI_600 = 1'b0;
    repeat (10) @(negedge USB_CLK);
    chk("reset_outputs", 32'({CIS_MODE, CIS_CLK, CIS_SP, CIS_LED_RED, CIS_LED_GREEN, CIS_LED_BLUE,
        ADC_CLK, USB_WR_L, SCOPE_SYNC, BUSY}), 32'(10'b0000000100));
    chk("reset_line_cnt", 32'(LINE_CNT), 0);
    chk("reset_color", 32'(COLOR), 0);
    RST_L = 1'b1;
    p = ADC_CLK; rises = 0; hi = 0; n2 = 0;
    repeat (36) begin
      @(negedge USB_CLK);
      rises += int'(ADC_CLK && !p);
      hi += int'(ADC_CLK);
      p = ADC_CLK;
      if (CIS_CLK || !USB_WR_L || BUSY || CIS_SP) n2++;
    end
    chk("idle_adc_rises", rises, 6);
    chk("idle_adc_high", hi, 18);
    chk("idle_quiet", n2, 0);
    q.push_back('{0, 0, 0, 0, 3'b100, 0});
    EN = 1'b1;
    wait_sp(40, n);
    for (int i = 0; i < 6; i++) begin
      v_cis = {v_cis[4:0], CIS_CLK};
      v_adc = {v_adc[4:0], ADC_CLK};
      v_wr = {v_wr[4:0], USB_WR_L};
      v_sp = {v_sp[4:0], CIS_SP};
      @(negedge USB_CLK);
    end
    chk("cis_clk_shape", 32'(v_cis), 32'(6'b111000));
    chk("adc_clk_shape", 32'(v_adc), 32'(6'b000111));
    chk("usb_wr_shape", 32'(v_wr), 32'(6'b110111));
    chk("sp_first_period", 32'(v_sp), 32'(6'b111111));
    chk("sp_second_period", 32'(CIS_SP), 0);
    q.push_back('{0, 1, 1, 0, 3'b010, L300});
    q.push_back('{0, 2, 2, 0, 3'b001, L300});
    q.push_back('{0, 3, 0, 0, 3'b100, L300});
    repeat (3) wait_sp(2000, n);
    repeat (30 * DIV) @(negedge USB_CLK);
    DPI_600 = 1'b1;
    q.push_back('{0, 4, 1, 1, 3'b010, L300});
    wait_sp(2000, n);
    repeat (30 * DIV) @(negedge USB_CLK);
    DPI_600 = 1'b0;
    q.push_back('{0, 5, 2, 0, 3'b001, L600});
    wait_sp(2000, n);
    repeat (59 * DIV) @(negedge USB_CLK);
    EN = 1'b0;
    q.push_back('{1, 6, 0, 0, 3'b000, L300});
    wait_idle(2000, n);
    n2 = 0;
    repeat (30) begin
      @(negedge USB_CLK);
      if (CIS_CLK || CIS_SP || !USB_WR_L || BUSY) n2++;
    end
    chk("stopped_quiet", n2, 0);
    q.push_back('{0, 0, 0, 0, 3'b100, 0});
    EN = 1'b1;
    wait_sp(40, n);
    repeat (49 * DIV) @(negedge USB_CLK);
    EN = 1'b0;
    repeat (30 * DIV) @(negedge USB_CLK);
    chk("drain_busy", 32'(BUSY), 1);
    EN = 1'b1;
    q.push_back('{0, 1, 1, 0, 3'b010, L300});
    wait_sp(2000, n);
    repeat (89 * DIV + 3) @(negedge USB_CLK);
    q.push_back('{1, 0, 0, 0, 3'b000, 0});
    #2 RST_L = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({CIS_MODE, CIS_CLK, CIS_SP, CIS_LED_RED, CIS_LED_GREEN, CIS_LED_BLUE,
        ADC_CLK, USB_WR_L, SCOPE_SYNC, BUSY}), 32'(10'b0000000100));
    chk("async_reset_line_cnt", 32'(LINE_CNT), 0);
    chk("async_reset_color", 32'(COLOR), 0);
    repeat (3) @(negedge USB_CLK);
    q.push_back('{0, 0, 0, 0, 3'b100, 0});
    RST_L = 1'b1;
    @(negedge USB_CLK);
    chk("arm_busy", 32'(BUSY), 1);
    chk("arm_cis_clk", 32'(CIS_CLK), 0);
    wait_sp(40, n);
    chk("arm_to_run_cycles", n, 5);
    repeat (4) @(negedge USB_CLK);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
